// File: rtl/scratch_rom_pkg.sv
// Shared types and constants for the scratch ROM arbiter.
//   SCRATCH_AW : default SDRAM word address width
//   SCRATCH_DW : default SDRAM read data width
//   state_e    : arbiter FSM states
package scratch_rom_pkg;

  localparam int unsigned SCRATCH_AW = 22;
  localparam int unsigned SCRATCH_DW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StWaitData
  } state_e;

endpackage

// File: rtl/scratch_rom_arb_if.sv
// SDRAM single read port between the ROM arbiter (master) and the framework
// SDRAM controller (slave).
//   sdram_req  : fetch request, held until sdram_ack
//   sdram_addr : fetch word address, stable while sdram_req is high
//   sdram_ack  : controller accepted the request
//   data_rdy   : single-cycle pulse, data_read valid
//   data_read  : returned word
interface scratch_rom_arb_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 32
);

  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_rdy;
  logic [DW-1:0] data_read;

  modport master (
    output sdram_req,
    output sdram_addr,
    input  sdram_ack,
    input  data_rdy,
    input  data_read
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    output sdram_ack,
    output data_rdy,
    output data_read
  );

endinterface

// File: rtl/scratch_rr_picker.sv
// Combinational cyclic priority encoder.
//   pending : per-slot request vector
//   ptr     : slot with highest round-robin priority
//   any     : at least one slot pending
//   winner  : first pending slot at or after ptr, cyclic
// With SCRATCH_ROMARB_PRIO_EN defined, slot 0 wins whenever it is pending and
// the remaining slots rotate among themselves.
module scratch_rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         pending,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW:0] idx;

  always_comb begin
    any    = |pending;
    winner = '0;
    idx    = '0;
    // Walk from the far end back to ptr so the nearest pending slot is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW + 1)'(k);
      if (idx >= (PW + 1)'(NREQ)) begin
        idx = idx - (PW + 1)'(NREQ);
      end
      if (pending[idx[PW-1:0]]) begin
        winner = idx[PW-1:0];
      end
    end
`ifdef SCRATCH_ROMARB_PRIO_EN
    if (pending[0]) begin
      winner = '0;
    end
`endif
  end

endmodule

// File: rtl/scratch_rom_arb.sv
// Shares one SDRAM read port among NREQ ROM requesters, each with a one-word
// cache. Round-robin arbitration; refresh allowed while idle.
// Optional macro SCRATCH_ROMARB_PRIO_EN: slot 0 (main CPU) always wins when
// pending; other slots rotate.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   downloading  : ROM download in progress (flushes caches, blocks fetches)
//   loop_rst     : framework loop reset (same effect as downloading)
//   slot_cs      : per-slot read request (level)
//   slot_addr    : per-slot word address, slot i at [i*AW +: AW]
//   slot_ok      : slot i cache holds data for its current address
//   slot_dout    : per-slot cached word, slot i at [i*DW +: DW]
//   sdram        : SDRAM read port (master side)
//   refresh_en   : controller may refresh
module scratch_rom_arb
  import scratch_rom_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = SCRATCH_AW,
  parameter int unsigned DW   = SCRATCH_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   downloading,
  input  logic                   loop_rst,
  input  logic [NREQ-1:0]        slot_cs,
  input  logic [NREQ*AW-1:0]     slot_addr,
  output logic [NREQ-1:0]        slot_ok,
  output logic [NREQ*DW-1:0]     slot_dout,
  scratch_rom_arb_if.master      sdram,
  output logic                   refresh_en
);

  localparam int unsigned PW = $clog2(NREQ);

  state_e          state_q;
  logic            req_q;
  logic [AW-1:0]   addr_q;
  logic [PW-1:0]   sel_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] cache_vld_q;
  logic [AW-1:0]   cache_addr_q [NREQ];
  logic [DW-1:0]   cache_data_q [NREQ];

  logic [AW-1:0]   addr_a [NREQ];
  logic [NREQ-1:0] hit;
  logic [NREQ-1:0] pending;
  logic            any;
  logic [PW-1:0]   winner;
  logic            blocked;
  logic            capture;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign addr_a[g]              = slot_addr[g*AW +: AW];
    assign hit[g]                 = cache_vld_q[g] && (cache_addr_q[g] == addr_a[g]);
    assign slot_dout[g*DW +: DW]  = cache_data_q[g];
  end

  assign slot_ok = slot_cs & hit;
  assign pending = slot_cs & ~hit;
  assign blocked = downloading | loop_rst;

  scratch_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .pending (pending),
    .ptr     (ptr_q),
    .any     (any),
    .winner  (winner)
  );

  // Data accepted either together with the ack or later in WAIT_DATA.
  always_comb begin
    capture = 1'b0;
    if (state_q == StWaitAck) begin
      capture = sdram.sdram_ack && sdram.data_rdy;
    end else if (state_q == StWaitData) begin
      capture = sdram.data_rdy;
    end
  end

  // rst gates the output so it reads 0 while reset is held.
  assign refresh_en = rst && (state_q == StIdle) && (!any || blocked);

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      cache_vld_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cache_addr_q[i] <= '0;
        cache_data_q[i] <= '0;
      end
    end else begin
      if (blocked) begin
        cache_vld_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (any && !blocked) begin
            addr_q  <= addr_a[winner];
            req_q   <= 1'b1;
            sel_q   <= winner;
            state_q <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (sdram.sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= sdram.data_rdy ? StIdle : StWaitData;
          end
        end
        StWaitData: begin
          if (sdram.data_rdy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // The issued address is cached, so a slot whose address moved keeps missing.
      if (capture) begin
        cache_data_q[sel_q] <= sdram.data_read;
        cache_addr_q[sel_q] <= addr_q;
        if (!blocked) begin
          cache_vld_q[sel_q] <= 1'b1;
        end
        ptr_q <= (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scratch_rom_arb.sv
module tb_scratch_rom_arb;

  localparam int NREQ = 4;
  localparam int AW   = 22;
  localparam int DW   = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                downloading = 1'b0;
  logic                loop_rst = 1'b0;
  logic [NREQ-1:0]     slot_cs = '0;
  logic [AW-1:0]       sa [NREQ];
  logic [NREQ*AW-1:0]  slot_addr;
  logic [NREQ-1:0]     slot_ok;
  logic [NREQ*DW-1:0]  slot_dout;
  logic                refresh_en;

  scratch_rom_arb_if #(.AW(AW), .DW(DW)) sdram ();

  scratch_rom_arb #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram       (sdram),
    .refresh_en  (refresh_en)
  );

  always #5 clk = ~clk;

  always_comb begin
    slot_addr = '0;
    for (int i = 0; i < NREQ; i++) slot_addr[i*AW +: AW] = sa[i];
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: what each slot's cache should hold, and the rotation pointer.
  bit            m_vld  [NREQ];
  logic [AW-1:0] m_addr [NREQ];
  logic [DW-1:0] m_data [NREQ];
  int            m_ptr;

  function automatic bit m_hit(int i);
    return slot_cs[i] && m_vld[i] && (m_addr[i] == sa[i]);
  endfunction

  function automatic logic [NREQ-1:0] m_ok();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = m_hit(i);
    return v;
  endfunction

  // Who the spec says should be granted next; -1 when nothing pending.
  function automatic int m_pick();
    bit p [NREQ];
    for (int i = 0; i < NREQ; i++) p[i] = slot_cs[i] && !m_hit(i);
`ifdef SCRATCH_ROMARB_PRIO_EN
    if (p[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (p[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_vld[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0;
  endtask

  task automatic m_fill(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_vld[s] = 1; m_addr[s] = a; m_data[s] = d;
    m_ptr = (s + 1) % NREQ;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Controller emulation: wait for a request, ack after ack_dly cycles, then
  // data ack-relative rdy_dly cycles later (0 = same cycle as ack).
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] d,
                       output logic [AW-1:0] a, output bit ok);
    ok = 0;
    a  = '0;
    for (int n = 0; n < 50; n++) begin
      if (sdram.sdram_req === 1'b1) begin
        ok = 1;
        break;
      end
      cyc();
    end
    if (!ok) return;
    a = sdram.sdram_addr;
    repeat (ack_dly) cyc();
    sdram.sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      sdram.data_rdy  = 1'b1;
      sdram.data_read = d;
    end
    cyc();
    sdram.sdram_ack = 1'b0;
    sdram.data_rdy  = 1'b0;
    if (rdy_dly > 0) begin
      repeat (rdy_dly - 1) cyc();
      sdram.data_rdy  = 1'b1;
      sdram.data_read = d;
      cyc();
      sdram.data_rdy = 1'b0;
    end
  endtask

  // Serve whatever the model says is pending, checking each grant's address.
  task automatic drain(input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    int e;
    for (int n = 0; n < 2 * NREQ; n++) begin
      e = m_pick();
      if (e < 0) break;
      d = $urandom;
      serve($urandom_range(0, 3), $urandom_range(0, 3), d, a, ok);
      n_chk++;
      if (ok !== 1'b1 || a !== sa[e]) begin
        n_fail++;
        $display("FAIL %s grant: got req=%0b addr=%h expected addr=%h (slot %0d)",
                 tag, ok, a, sa[e], e);
      end
      m_fill(e, sa[e], d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    n_chk++;
    if (sdram.sdram_req !== 1'b0) begin
      n_fail++; $display("FAIL reset req: got %b expected 0", sdram.sdram_req);
    end
    n_chk++;
    if (refresh_en !== 1'b0) begin
      n_fail++; $display("FAIL reset refresh: got %b expected 0", refresh_en);
    end
    n_chk++;
    if (slot_ok !== '0 || slot_dout !== '0) begin
      n_fail++; $display("FAIL reset slots: got ok=%h dout=%h expected 0", slot_ok, slot_dout);
    end
    rst = 1'b1;
    m_reset();
    #1;
    n_chk++;
    if (refresh_en !== 1'b1) begin
      n_fail++; $display("FAIL idle refresh: got %b expected 1", refresh_en);
    end
  endtask

  task automatic test_single_miss();
    logic [AW-1:0] a;
    bit ok, seen;
    cyc();
    sa[1]   = 22'h00123;
    slot_cs = 4'b0010;
    #1;
    n_chk++;
    if (sdram.sdram_req !== 1'b0 || refresh_en !== 1'b0) begin
      n_fail++; $display("FAIL miss same-cycle: got req=%b refresh=%b expected 0 0",
                         sdram.sdram_req, refresh_en);
    end
    cyc();
    n_chk++;
    if (sdram.sdram_req !== 1'b1 || sdram.sdram_addr !== 22'h00123) begin
      n_fail++; $display("FAIL miss issue: got req=%b addr=%h expected 1 00123",
                         sdram.sdram_req, sdram.sdram_addr);
    end
    serve(3, 4, 32'hDEADBEEF, a, ok);
    m_fill(1, 22'h00123, 32'hDEADBEEF);
    n_chk++;
    if (slot_ok !== m_ok() || slot_dout[DW +: DW] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL miss fill: got ok=%b dout=%h expected ok=%b dout=deadbeef",
                         slot_ok, slot_dout[DW +: DW], m_ok());
    end
    seen = 0;
    repeat (6) begin
      cyc();
      if (sdram.sdram_req !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL miss rerequest: got req after fill, expected none");
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    int e, got;
    int order [5];
    int want  [5];
`ifdef SCRATCH_ROMARB_PRIO_EN
    want = '{0, 0, 1, 2, 3};
`else
    want = '{0, 1, 2, 3, 0};
`endif
    cyc(); rst = 1'b0; #1; cyc(); rst = 1'b1;
    m_reset();
    for (int i = 0; i < NREQ; i++) sa[i] = AW'(($urandom & 32'hFFFFF) | (i << 20));
    slot_cs = 4'hF;
    for (int n = 0; n < 5; n++) begin
      e = m_pick();
      d = $urandom;
      serve($urandom_range(0, 3), $urandom_range(0, 4), d, a, ok);
      got = -1;
      for (int j = 0; j < NREQ; j++) if (a === sa[j]) got = j;
      order[n] = got;
      n_chk++;
      if (ok !== 1'b1 || e < 0 || a !== sa[e]) begin
        n_fail++; $display("FAIL rr grant %0d: got addr=%h expected slot %0d", n, a, e);
      end
      if (e >= 0) m_fill(e, sa[e], d);
      if (n == 0) sa[0] = sa[0] ^ 22'h1;
    end
    n_chk++;
    if (order !== want) begin
      n_fail++; $display("FAIL rr order: got %0d %0d %0d %0d %0d expected %0d %0d %0d %0d %0d",
                         order[0], order[1], order[2], order[3], order[4],
                         want[0], want[1], want[2], want[3], want[4]);
    end
    n_chk++;
    if (slot_ok !== 4'hF) begin
      n_fail++; $display("FAIL rr all cached: got ok=%b expected 1111", slot_ok);
    end
  endtask

  task automatic test_addr_change();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    d = $urandom;
    slot_cs = 4'b0100;
    sa[2]   = 22'h00010;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (sdram.sdram_req === 1'b1) begin ok = 1; break; end
    end
    n_chk++;
    if (ok !== 1'b1 || sdram.sdram_addr !== 22'h00010) begin
      n_fail++; $display("FAIL chg issue: got req=%b addr=%h expected 1 00010",
                         ok, sdram.sdram_addr);
    end
    sdram.sdram_ack = 1'b1; cyc(); sdram.sdram_ack = 1'b0;
    sa[2] = 22'h00011;
    cyc();
    sdram.data_rdy = 1'b1; sdram.data_read = d; cyc(); sdram.data_rdy = 1'b0;
    m_fill(2, 22'h00010, d);
    n_chk++;
    if (slot_ok !== m_ok() || slot_dout[2*DW +: DW] !== d) begin
      n_fail++; $display("FAIL chg cache: got ok=%b dout=%h expected ok=%b dout=%h",
                         slot_ok, slot_dout[2*DW +: DW], m_ok(), d);
    end
    cyc();
    n_chk++;
    if (sdram.sdram_req !== 1'b1 || sdram.sdram_addr !== 22'h00011) begin
      n_fail++; $display("FAIL chg refetch: got req=%b addr=%h expected 1 00011",
                         sdram.sdram_req, sdram.sdram_addr);
    end
    d = $urandom;
    serve(1, 1, d, a, ok);
    m_fill(2, a, d);
  endtask

  task automatic test_download();
    bit bad;
    slot_cs = 4'hF;
    for (int i = 0; i < NREQ; i++) sa[i] = AW'(($urandom & 32'hFFFF) | ((i + 4) << 16));
    drain("dl prefill");
    n_chk++;
    if (slot_ok !== 4'hF) begin
      n_fail++; $display("FAIL dl prefill: got ok=%b expected 1111", slot_ok);
    end
    downloading = 1'b1;
    cyc();
    n_chk++;
    if (slot_ok !== '0 || sdram.sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
      n_fail++; $display("FAIL dl hold: got ok=%b req=%b refresh=%b expected 0000 0 1",
                         slot_ok, sdram.sdram_req, refresh_en);
    end
    bad = 0;
    repeat (5) begin
      cyc();
      if (sdram.sdram_req !== 1'b0 || slot_ok !== '0 || refresh_en !== 1'b1) bad = 1;
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL dl steady: got activity during download, expected none");
    end
    downloading = 1'b0;
    for (int i = 0; i < NREQ; i++) m_vld[i] = 0;
    drain("dl refetch");
    n_chk++;
    if (slot_ok !== 4'hF) begin
      n_fail++; $display("FAIL dl refetch: got ok=%b expected 1111", slot_ok);
    end
    loop_rst = 1'b1;
    cyc();
    n_chk++;
    if (slot_ok !== '0 || refresh_en !== 1'b1) begin
      n_fail++; $display("FAIL loop_rst flush: got ok=%b refresh=%b expected 0000 1",
                         slot_ok, refresh_en);
    end
    loop_rst = 1'b0;
    for (int i = 0; i < NREQ; i++) m_vld[i] = 0;
    drain("loop_rst refetch");
  endtask

  task automatic test_same_cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok, seen;
    d = $urandom;
    slot_cs = 4'b1000;
    sa[3]   = 22'h2ABCD;
    serve(2, 0, d, a, ok);
    n_chk++;
    if (ok !== 1'b1 || a !== 22'h2ABCD) begin
      n_fail++; $display("FAIL same-cycle issue: got req=%b addr=%h expected 1 2abcd", ok, a);
    end
    m_fill(3, 22'h2ABCD, d);
    n_chk++;
    if (slot_ok !== m_ok() || slot_dout[3*DW +: DW] !== d) begin
      n_fail++; $display("FAIL same-cycle fill: got ok=%b dout=%h expected ok=%b dout=%h",
                         slot_ok, slot_dout[3*DW +: DW], m_ok(), d);
    end
    seen = 0;
    repeat (6) begin
      cyc();
      if (sdram.sdram_req !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen !== 1'b0 || refresh_en !== 1'b1) begin
      n_fail++; $display("FAIL same-cycle idle: got rerequest=%b refresh=%b expected 0 1",
                         seen, refresh_en);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    slot_cs = 4'b0010;
    sa[1]   = 22'h1F00F;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (sdram.sdram_req === 1'b1) begin ok = 1; break; end
    end
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rst-mid issue: got req=0 expected 1");
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (sdram.sdram_req !== 1'b0 || slot_ok !== '0) begin
      n_fail++; $display("FAIL rst-mid async: got req=%b ok=%b expected 0 0000",
                         sdram.sdram_req, slot_ok);
    end
    cyc(); cyc();
    rst = 1'b1;
    m_reset();
    d = $urandom;
    serve(1, 2, d, a, ok);
    n_chk++;
    if (ok !== 1'b1 || a !== 22'h1F00F) begin
      n_fail++; $display("FAIL rst-mid rerequest: got req=%b addr=%h expected 1 1f00f", ok, a);
    end
    m_fill(1, 22'h1F00F, d);
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [4];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    int e;
    pool = '{22'h00000, 22'h3FFFFF, 22'h155555, 22'h0000F0};
    for (int it = 0; it < 80; it++) begin
      slot_cs = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) sa[i] = pool[$urandom_range(0, 3)];
      #1;
      n_chk++;
      if (slot_ok !== m_ok()) begin
        n_fail++; $display("FAIL rnd hit %0d: got ok=%b expected %b", it, slot_ok, m_ok());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (m_hit(i)) begin
          n_chk++;
          if (slot_dout[i*DW +: DW] !== m_data[i]) begin
            n_fail++; $display("FAIL rnd dout %0d slot %0d: got %h expected %h",
                               it, i, slot_dout[i*DW +: DW], m_data[i]);
          end
        end
      end
      e = m_pick();
      if (e < 0) begin
        n_chk++;
        if (refresh_en !== 1'b1) begin
          n_fail++; $display("FAIL rnd refresh %0d: got %b expected 1", it, refresh_en);
        end
        cyc();
        n_chk++;
        if (sdram.sdram_req !== 1'b0) begin
          n_fail++; $display("FAIL rnd spurious req %0d: got 1 expected 0", it);
        end
      end else begin
        d = $urandom;
        serve($urandom_range(0, 4), $urandom_range(0, 4), d, a, ok);
        n_chk++;
        if (ok !== 1'b1 || a !== sa[e]) begin
          n_fail++; $display("FAIL rnd grant %0d: got req=%b addr=%h expected addr=%h",
                             it, ok, a, sa[e]);
        end
        m_fill(e, sa[e], d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) sa[i] = '0;
    sdram.sdram_ack = 1'b0;
    sdram.data_rdy  = 1'b0;
    sdram.data_read = '0;
    m_reset();
    test_reset();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_download();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
